// File: rtl/apb_master_bridge_if.sv
// Host command/response port plus APB requester signals of the APB master bridge.
// Handshakes: a beat transfers on a rising edge where valid and ready are both 1;
// once raised, valid and its payload hold until that edge.
interface apb_master_bridge_if #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_write;
    logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
    logic [AMBA_WORD-1:0]       cmd_wdata;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [AMBA_WORD-1:0]       rsp_rdata;
    logic                       rsp_err;
    logic                       rsp_timeout;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: one host command at a time runs SETUP/ACCESS with PREADY wait
// states and an optional ACCESS-cycle timeout, then holds a response until taken.
module apb_master_bridge #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                clk,
    input  logic                rst,
    apb_master_bridge_if.master bus,
    output logic [1:0]          o_dbg_state
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [CNT_W-1:0]           r_cnt;
    logic                       w_to_hit;
    logic                       r_pwrite;
    logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
    logic [AMBA_WORD-1:0]       r_pwdata;
    logic [AMBA_WORD-1:0]       r_rsp_rdata;
    logic                       r_rsp_err;
    logic                       r_rsp_timeout;

    assign w_to_hit = TO_EN && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    // Completion takes priority over timeout on the last allowed ACCESS cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (bus.cmd_valid) w_next_state = S_SETUP;
            S_SETUP:  w_next_state = S_ACCESS;
            S_ACCESS: if (bus.PREADY || w_to_hit) w_next_state = S_RESP;
            S_RESP:   if (bus.rsp_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // cmd_ready is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.PSEL      = 1'b0;
        bus.PENABLE   = 1'b0;
        case (r_state)
            S_IDLE:   bus.cmd_ready = rst;
            S_SETUP:  bus.PSEL = 1'b1;
            S_ACCESS: begin
                bus.PSEL    = 1'b1;
                bus.PENABLE = 1'b1;
            end
            S_RESP:   bus.rsp_valid = 1'b1;
            default:  bus.cmd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt         <= '0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_pwrite <= bus.cmd_write;
                        r_paddr  <= bus.cmd_addr;
                        r_pwdata <= bus.cmd_wdata;
                    end
                end
                S_SETUP: r_cnt <= '0;
                S_ACCESS: begin
                    if (bus.PREADY) begin
                        r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                        r_rsp_err     <= bus.PSLVERR;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_to_hit) begin
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign o_dbg_state     = r_state;
endmodule
